dip_replacement_unit: RTL and testbench

- Parametrised replacement-policy engine for the set-associative caches (d_cache, i_cache).
- Generalises the fixed 4-way pseudo-LRU to N-way tree-PLRU and adds selectable insertion policies: LRU, LIP and BIP.
- Adds dynamic set-dueling (DIP) with a saturating PSEL counter.
- The cache controller queries the victim combinationally. It reports accesses and fills; the unit updates per-set state on the clock edge.

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/dip_replacement_unit_plru_tree.sv | 72 +++++++
 rtl/dip_replacement_unit.sv | 154 +++++++++++++++
 tb/tb_dip_replacement_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared definitions for the cache replacement logic.
//   ReplPolicy      : insertion policy selector, encoded as driven on policy_mode.
//   plru_node_count : number of tree-PLRU node bits for a given associativity.
package mips_core_pkg;

  typedef enum logic [1:0] {
    REPL_LRU = 2'd0,
    REPL_LIP = 2'd1,
    REPL_BIP = 2'd2,
    REPL_DIP = 2'd3
  } ReplPolicy;

  // A binary tree over N leaves has N-1 internal nodes.
  function automatic int plru_node_count(input int assoc);
    return assoc - 1;
  endfunction

endpackage

// File: rtl/dip_replacement_unit_plru_tree.sv
// One cache set's tree-PLRU state.
//   clk, rst        : clock, asynchronous active-high reset (all node bits to 0)
//   upd_en_i        : apply an update to this set at the next edge
//   upd_promote_i   : 1 = point the path away from upd_way_i (MRU),
//                     0 = point the path toward upd_way_i (LRU position)
//   upd_way_i       : way whose root-to-leaf path is rewritten
//   victim_way_o    : way reached by following the node bits from the root
// Node 0 is the root, node k has children 2k+1 / 2k+2, leaves are ways in
// ascending order; a node bit of 1 means the victim lies in the upper half.
module plru_tree
  import mips_core_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             upd_en_i,
  input  logic                             upd_promote_i,
  input  logic [$clog2(ASSOCIATIVITY)-1:0] upd_way_i,
  output logic [$clog2(ASSOCIATIVITY)-1:0] victim_way_o
);

  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  localparam int NODES = plru_node_count(ASSOCIATIVITY);

  logic [NODES-1:0]         tree_q;
  logic [NODES-1:0]         tree_d;
  logic [ASSOCIATIVITY-1:0] way_match;

  // Each node knows its level and its position within that level; it lies on
  // the path of a way when the way's top LVL bits equal that position, and the
  // way's next bit says which child the path takes.
  for (genvar n = 0; n < NODES; n++) begin : g_node
    localparam int LVL = $clog2(n + 2) - 1;
    localparam int POS = n - ((1 << LVL) - 1);

    logic on_path;
    logic dir;

    assign dir     = upd_way_i[WAY_W-1-LVL];
    assign on_path = ((int'(upd_way_i) >> (WAY_W - LVL)) == POS);
    assign tree_d[n] = (upd_en_i && on_path) ? (upd_promote_i ? ~dir : dir)
                                             : tree_q[n];
  end

  // A way is the victim when every node on its path points toward it.
  for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_way
    logic [WAY_W-1:0] lvl_ok;
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
      localparam int NODE = ((1 << l) - 1) + (w >> (WAY_W - l));
      localparam int DIR  = (w >> (WAY_W - 1 - l)) & 1;
      assign lvl_ok[l] = (tree_q[NODE] == (DIR != 0));
    end
    assign way_match[w] = &lvl_ok;
  end

  // Exactly one way matches for any tree state, so this is a plain encoder.
  always_comb begin
    victim_way_o = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (way_match[w]) victim_way_o = WAY_W'(w);
    end
  end

  // NOTE: the node bits steer the victim immediately after reset, so they are
  // flops with an async reset rather than an uninitialised memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tree_q <= '0;
    else     tree_q <= tree_d;
  end

endmodule

// File: rtl/dip_replacement_unit.sv
// Replacement-policy engine for a set-associative cache: N-way tree-PLRU per
// set with LRU / LIP / BIP insertion and DIP set-dueling.
//   clk, rst          : clock, asynchronous active-high reset
//   policy_mode       : 0 LRU, 1 LIP, 2 BIP, 3 dynamic DIP
//   access_valid/index/hit/way : completed lookup; a hit promotes the way
//   fill_valid/index/way       : completed refill; inserted per policy
//   query_index/valid_mask     : set whose victim is requested, its valid bits
//   victim_way        : lowest invalid way, else tree victim (combinational)
//   psel              : set-dueling selector
//   follower_bip      : followers currently insert with BIP (psel MSB)
module dip_replacement_unit
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH   = 5,
  parameter int ASSOCIATIVITY = 4,
  parameter int PSEL_WIDTH    = 10,
  parameter int BIP_EPS_LOG2  = 5,
  parameter int LEADER_BITS   = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       policy_mode,
  input  logic                             access_valid,
  input  logic [INDEX_WIDTH-1:0]           access_index,
  input  logic                             access_hit,
  input  logic [$clog2(ASSOCIATIVITY)-1:0] access_way,
  input  logic                             fill_valid,
  input  logic [INDEX_WIDTH-1:0]           fill_index,
  input  logic [$clog2(ASSOCIATIVITY)-1:0] fill_way,
  input  logic [INDEX_WIDTH-1:0]           query_index,
  input  logic [ASSOCIATIVITY-1:0]         query_valid_mask,
  output logic [$clog2(ASSOCIATIVITY)-1:0] victim_way,
  output logic [PSEL_WIDTH-1:0]            psel,
  output logic                             follower_bip
);

  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [PSEL_WIDTH-1:0] PSEL_RESET = {1'b0, {(PSEL_WIDTH-1){1'b1}}};

  if (ASSOCIATIVITY < 2 || (ASSOCIATIVITY & (ASSOCIATIVITY - 1)) != 0) begin : g_bad_assoc
    $error("dip_replacement_unit: ASSOCIATIVITY must be a power of 2 and >= 2");
  end
  if (LEADER_BITS < 1 || LEADER_BITS > INDEX_WIDTH) begin : g_bad_leader
    $error("dip_replacement_unit: LEADER_BITS must be in 1..INDEX_WIDTH");
  end

  ReplPolicy mode;
  assign mode = ReplPolicy'(policy_mode);

  logic [PSEL_WIDTH-1:0]   psel_q, psel_d;
  logic [BIP_EPS_LOG2-1:0] bip_cnt_q, bip_cnt_d;

  // Set classification from the low index bits.
  logic fill_lru_leader, fill_bip_leader;
  logic acc_lru_leader, acc_bip_leader;

  assign fill_lru_leader = (fill_index[LEADER_BITS-1:0] == '0);
  assign fill_bip_leader = (&fill_index[LEADER_BITS-1:0]);
  assign acc_lru_leader  = (access_index[LEADER_BITS-1:0] == '0);
  assign acc_bip_leader  = (&access_index[LEADER_BITS-1:0]);

  logic fill_use_bip;
  logic fill_promote;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    fill_use_bip = 1'b0;
    fill_promote = 1'b1;
    case (mode)
      REPL_LRU: fill_promote = 1'b1;
      REPL_LIP: fill_promote = 1'b0;
      REPL_BIP: fill_use_bip = 1'b1;
      REPL_DIP: begin
        if (fill_bip_leader)       fill_use_bip = 1'b1;
        else if (!fill_lru_leader) fill_use_bip = psel_q[PSEL_WIDTH-1];
      end
      default: fill_promote = 1'b1;
    endcase
    // BIP inserts at MRU only when the epsilon counter is at zero.
    if (fill_use_bip) fill_promote = (bip_cnt_q == '0);
  end

  always_comb begin
    psel_d    = psel_q;
    bip_cnt_d = bip_cnt_q;
    if (mode == REPL_DIP && access_valid && !access_hit) begin
      if (acc_lru_leader) begin
        if (psel_q != '1) psel_d = psel_q + 1'b1;
      end else if (acc_bip_leader) begin
        if (psel_q != '0) psel_d = psel_q - 1'b1;
      end
    end
    if (fill_valid && fill_use_bip) bip_cnt_d = bip_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_q    <= PSEL_RESET;
      bip_cnt_q <= '0;
    end else begin
      psel_q    <= psel_d;
      bip_cnt_q <= bip_cnt_d;
    end
  end

  // A fill owns its set for the cycle; a hit to the same set loses its
  // tree update (its PSEL effect above is unaffected).
  logic hit_update;
  assign hit_update = access_valid && access_hit &&
                      !(fill_valid && (fill_index == access_index));

  logic [WAY_W-1:0] set_victim [DEPTH];

  for (genvar s = 0; s < DEPTH; s++) begin : g_set
    logic fill_sel;
    logic hit_sel;

    assign fill_sel = fill_valid && (fill_index == INDEX_WIDTH'(s));
    assign hit_sel  = hit_update && (access_index == INDEX_WIDTH'(s));

    plru_tree #(
      .ASSOCIATIVITY(ASSOCIATIVITY)
    ) u_tree (
      .clk          (clk),
      .rst          (rst),
      .upd_en_i     (fill_sel | hit_sel),
      .upd_promote_i(fill_sel ? fill_promote : 1'b1),
      .upd_way_i    (fill_sel ? fill_way : access_way),
      .victim_way_o (set_victim[s])
    );
  end

  // Invalid ways are always preferred; lowest-numbered first.
  logic [WAY_W-1:0] invalid_way;
  logic             invalid_found;

  always_comb begin
    invalid_way   = '0;
    invalid_found = 1'b0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (!invalid_found && !query_valid_mask[w]) begin
        invalid_way   = WAY_W'(w);
        invalid_found = 1'b1;
      end
    end
  end

  assign victim_way   = invalid_found ? invalid_way : set_victim[query_index];
  assign psel         = psel_q;
  assign follower_bip = psel_q[PSEL_WIDTH-1];

endmodule

// File: tb/tb_dip_replacement_unit.sv
module tb_dip_replacement_unit;

  localparam int IW     = 5;
  localparam int A      = 4;
  localparam int WW     = 2;
  localparam int PW     = 10;
  localparam int DEPTH  = 32;
  localparam int LEVELS = 2;
  localparam int PMAX   = (1 << PW) - 1;
  localparam int PHALF  = 1 << (PW - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    policy_mode;
  logic          access_valid;
  logic [IW-1:0] access_index;
  logic          access_hit;
  logic [WW-1:0] access_way;
  logic          fill_valid;
  logic [IW-1:0] fill_index;
  logic [WW-1:0] fill_way;
  logic [IW-1:0] query_index;
  logic [A-1:0]  query_valid_mask;
  logic [WW-1:0] victim_way;
  logic [PW-1:0] psel;
  logic          follower_bip;

  always #5 clk = ~clk;

  dip_replacement_unit dut (
    .clk             (clk),
    .rst             (rst),
    .policy_mode     (policy_mode),
    .access_valid    (access_valid),
    .access_index    (access_index),
    .access_hit      (access_hit),
    .access_way      (access_way),
    .fill_valid      (fill_valid),
    .fill_index      (fill_index),
    .fill_way        (fill_way),
    .query_index     (query_index),
    .query_valid_mask(query_valid_mask),
    .victim_way      (victim_way),
    .psel            (psel),
    .follower_bip    (follower_bip)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per set: node bits of the tree, walked from the root.
  bit m_tree [DEPTH][A];
  int m_psel;
  int m_bip;

  task automatic m_reset();
    for (int s = 0; s < DEPTH; s++)
      for (int n = 0; n < A; n++) m_tree[s][n] = 1'b0;
    m_psel = PHALF - 1;
    m_bip  = 0;
  endtask

  function automatic int m_victim(input int idx, input int mask);
    int node = 0;
    int way  = 0;
    for (int w = 0; w < A; w++)
      if (((mask >> w) & 1) == 0) return w;
    for (int l = 0; l < LEVELS; l++) begin
      way  = way * 2 + int'(m_tree[idx][node]);
      node = 2 * node + 1 + int'(m_tree[idx][node]);
    end
    return way;
  endfunction

  // Walk the path of 'way'; promote points each node away, demote toward.
  task automatic m_touch(input int idx, input int way, input bit promote);
    int node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      int d = (way >> (LEVELS - 1 - l)) & 1;
      m_tree[idx][node] = promote ? (d == 0) : (d != 0);
      node = 2 * node + 1 + d;
    end
  endtask

  task automatic m_step(input int mode, input bit av, input int ai, input bit ah,
                        input int aw, input bit fv, input int fi, input int fw);
    if (fv) begin
      bit bip  = 1'b0;
      bit prom = 1'b1;
      case (mode)
        1: prom = 1'b0;
        2: bip = 1'b1;
        3: bip = (fi % 8 == 7) ? 1'b1 : (fi % 8 == 0) ? 1'b0 : (m_psel >= PHALF);
        default: prom = 1'b1;
      endcase
      if (bip) begin
        prom  = (m_bip == 0);
        m_bip = (m_bip + 1) % 32;
      end
      m_touch(fi, fw, prom);
    end
    if (av && ah && !(fv && fi == ai)) m_touch(ai, aw, 1'b1);
    if (mode == 3 && av && !ah) begin
      if (ai % 8 == 0 && m_psel < PMAX) m_psel++;
      else if (ai % 8 == 7 && m_psel > 0) m_psel--;
    end
  endtask

  // One cycle: drive at the falling edge, check just after, step at the rise.
  task automatic cyc(input int mode, input bit av, input int ai, input bit ah,
                     input int aw, input bit fv, input int fi, input int fw,
                     input int qi, input int qm);
    policy_mode      = 2'(mode);
    access_valid     = av;
    access_index     = IW'(ai);
    access_hit       = ah;
    access_way       = WW'(aw);
    fill_valid       = fv;
    fill_index       = IW'(fi);
    fill_way         = WW'(fw);
    query_index      = IW'(qi);
    query_valid_mask = A'(qm);
    #1;
    check("victim", int'(victim_way), m_victim(qi, qm));
    check("psel", int'(psel), m_psel);
    check("follower_bip", int'(follower_bip), int'(m_psel >= PHALF));
    @(posedge clk);
    m_step(mode, av, ai, ah, aw, fv, fi, fw);
    @(negedge clk);
  endtask

  task automatic probe(input string tag, input int qi, input int qm, input int exp);
    query_index      = IW'(qi);
    query_valid_mask = A'(qm);
    #1;
    check(tag, int'(victim_way), exp);
  endtask

  task automatic rand_cycles(input int n);
    int mode = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 150 == 0) mode = int'($urandom_range(0, 3));
      cyc(mode,
          1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, A - 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, A - 1)),
          int'($urandom_range(0, DEPTH - 1)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15);
    end
  endtask

  initial begin
    rst = 1'b1;
    policy_mode = '0; access_valid = 1'b0; access_index = '0; access_hit = 1'b0;
    access_way = '0; fill_valid = 1'b0; fill_index = '0; fill_way = '0;
    query_index = '0; query_valid_mask = '1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    probe("reset_victim", 5, 15, 0);
    check("reset_psel", int'(psel), 511);
    check("reset_fbip", int'(follower_bip), 0);

    // Promote path, mode 0.
    cyc(0, 1, 5, 1, 0, 0, 0, 0, 5, 15);
    cyc(0, 1, 5, 1, 2, 0, 0, 0, 5, 15);
    probe("promote_w0w2", 5, 15, 1);
    cyc(0, 1, 5, 1, 1, 0, 0, 0, 5, 15);
    probe("promote_w1", 5, 15, 3);
    probe("other_set", 6, 15, 0);
    probe("invalid_pref", 5, 4'b1011, 2);

    // Set dueling, mode 3.
    cyc(3, 1, 7, 0, 0, 0, 0, 0, 7, 15);
    check("duel_bip_leader", int'(psel), 510);
    cyc(3, 1, 8, 0, 0, 0, 0, 0, 8, 15);
    cyc(3, 1, 8, 0, 0, 0, 0, 0, 8, 15);
    check("duel_lru_leader", int'(psel), 512);
    check("duel_fbip", int'(follower_bip), 1);
    cyc(3, 0, 0, 0, 0, 1, 10, 0, 9, 15);   // BIP fill with counter 0 -> MRU
    cyc(3, 0, 0, 0, 0, 1, 9, 3, 9, 15);    // counter 1 -> inserted at LRU
    probe("bip_demote", 9, 15, 3);

    // Saturation both ways.
    repeat (520) cyc(3, 1, 8, 0, 0, 0, 0, 0, 8, 15);
    check("psel_top", int'(psel), PMAX);
    cyc(3, 1, 8, 0, 0, 0, 0, 0, 8, 15);
    check("psel_sat_hi", int'(psel), PMAX);
    repeat (1030) cyc(3, 1, 15, 0, 0, 0, 0, 0, 15, 15);
    check("psel_bottom", int'(psel), 0);
    cyc(3, 1, 15, 0, 0, 0, 0, 0, 15, 15);
    check("psel_sat_lo", int'(psel), 0);

    // Fill (LIP) and hit on the same set and way: the demote wins.
    cyc(1, 1, 4, 1, 1, 1, 4, 1, 4, 15);
    probe("collision", 4, 15, 1);

    rand_cycles(3000);

    // Asynchronous reset between clock edges, traffic still driven.
    query_valid_mask = '1;
    #3 rst = 1'b1;
    #1;
    check("areset_psel", int'(psel), 511);
    check("areset_fbip", int'(follower_bip), 0);
    check("areset_victim", int'(victim_way), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    rand_cycles(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
